// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default sizing for the FIFO write-side arbiter and its picker.
package fifo_arb_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int MAX_BURST_DEF  = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side request bundle plus the FIFO write port and arbiter status.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_write_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_write_en, fifo_data_in, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_write_en, fifo_data_in, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first valid index at or after the pointer, wrapping.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [ID_W-1:0]    i_rr_ptr,
  output logic [ID_W-1:0]    o_pick_id,
  output logic               o_pick_any
);

  logic [ID_W-1:0] w_idx;

  // Scan from farthest to nearest so the closest valid index is the one left standing
  always_comb begin
    o_pick_id  = {ID_W{1'b0}};
    o_pick_any = 1'b0;
    w_idx      = {ID_W{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = ID_W'((int'(i_rr_ptr) + k) % NUM_REQ);
      if (i_req_valid[w_idx]) begin
        o_pick_any = 1'b1;
        o_pick_id  = w_idx;
      end else begin
        o_pick_any = o_pick_any;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one sync_fifo write port among NUM_REQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF
) (
  input logic               i_clk,
  input logic               i_reset_n,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [ID_W-1:0]       r_owner;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [ID_W-1:0]       w_pick_id;
  logic                  w_pick_any;
  logic                  w_busy;
  logic                  w_owner_valid;
  logic                  w_owner_last;
  logic                  w_xfer;
  logic                  w_cap_hit;
  logic                  w_release;
  logic [NUM_REQ-1:0]    w_ready;
  logic [DATA_WIDTH-1:0] w_data;

  fifo_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req_valid (bus.req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_pick_id   (w_pick_id),
    .o_pick_any  (w_pick_any)
  );

  assign w_busy        = (r_state == BURST);
  assign w_owner_valid = bus.req_valid[r_owner];
  assign w_owner_last  = bus.req_last[r_owner];
  // Full gates the write in the same cycle; full is registered inside sync_fifo, so no loop
  assign w_xfer        = w_busy & w_owner_valid & ~bus.fifo_full;
  assign w_cap_hit     = ((r_beat_cnt + CNT_W'(1)) == CNT_W'(MAX_BURST));
  assign w_release     = (w_xfer & (w_owner_last | w_cap_hit)) | (w_busy & ~w_owner_valid);

  // Grant FSM state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant FSM next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_any) w_state_nxt = BURST;
        else            w_state_nxt = IDLE;
      end
      BURST: begin
        if (w_release) w_state_nxt = IDLE;
        else           w_state_nxt = BURST;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Owner, round-robin pointer and beat counter; owner clears on release so grant_id reads 0 when idle
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_owner    <= {ID_W{1'b0}};
      r_rr_ptr   <= {ID_W{1'b0}};
      r_beat_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == IDLE) && w_pick_any) begin
      r_owner    <= w_pick_id;
      r_rr_ptr   <= (w_pick_id == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : (w_pick_id + ID_W'(1));
      r_beat_cnt <= {CNT_W{1'b0}};
    end else if (w_release) begin
      r_owner    <= {ID_W{1'b0}};
      r_beat_cnt <= {CNT_W{1'b0}};
    end else if (w_xfer) begin
      r_beat_cnt <= r_beat_cnt + CNT_W'(1);
    end else begin
      r_beat_cnt <= r_beat_cnt;
    end
  end

  // Ready and data mux: only the owner's slice is ever routed to the FIFO
  always_comb begin
    w_ready = {NUM_REQ{1'b0}};
    w_data  = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_busy && (r_owner == ID_W'(k))) begin
        w_ready[k] = w_xfer;
        w_data     = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        w_ready[k] = 1'b0;
      end
    end
  end

  assign bus.req_ready     = w_ready;
  assign bus.fifo_write_en = w_xfer;
  assign bus.fifo_data_in  = w_data;
  assign bus.grant_id      = r_owner;
  assign bus.busy          = w_busy;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with producer queues and an 8-deep FIFO model.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus)
  );

  logic [8:0]    pq [NR][$];
  logic [7:0]    fq [$];
  logic          rd_en = 1'b0;
  int            n_checks = 0;
  int            n_pass = 0;
  int            n_ovf = 0;
  logic          s_wr;
  logic [7:0]    s_data;
  logic [NR-1:0] s_rdy;
  logic [1:0]    s_gid;
  logic          s_busy;
  logic [15:0]   wr_hist = 16'h0000;
  logic [1:0]    gid_log [$];
  logic [7:0]    e8;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic drive();
    logic [8:0] b;
    for (int k = 0; k < NR; k++) begin
      if (pq[k].size() > 0) begin
        b = pq[k][0];
        bus.req_valid[k] = 1'b1;
        bus.req_data[k*DW +: DW] = b[7:0];
        bus.req_last[k] = b[8];
      end else begin
        bus.req_valid[k] = 1'b0;
        bus.req_data[k*DW +: DW] = 8'h00;
        bus.req_last[k] = 1'b0;
      end
    end
  endtask

  // One clock: drive, sample before the edge, then commit FIFO and producer pops after it
  task automatic step();
    drive();
    #1;
    s_wr    = bus.fifo_write_en;
    s_data  = bus.fifo_data_in;
    s_rdy   = bus.req_ready;
    s_gid   = bus.grant_id;
    s_busy  = bus.busy;
    wr_hist = {wr_hist[14:0], s_wr};
    @(posedge clk);
    if (s_wr) begin
      if (fq.size() < 8) fq.push_back(s_data);
      else n_ovf++;
    end
    if (rd_en && fq.size() > 0) void'(fq.pop_front());
    rd_en = 1'b0;
    for (int k = 0; k < NR; k++) if (s_rdy[k]) void'(pq[k].pop_front());
    #1;
    bus.fifo_full = (fq.size() == 8);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;

    // Reset with a request already pending
    pq[0].push_back({1'b0, 8'h11});
    pq[0].push_back({1'b0, 8'h22});
    pq[0].push_back({1'b1, 8'h33});
    @(posedge clk);
    #1;
    drive();
    #1;
    check("rst_wr",   32'(bus.fifo_write_en), 32'd0);
    check("rst_data", 32'(bus.fifo_data_in),  32'd0);
    check("rst_rdy",  32'(bus.req_ready),     32'd0);
    check("rst_gid",  32'(bus.grant_id),      32'd0);
    check("rst_busy", 32'(bus.busy),          32'd0);
    reset_n = 1'b1;

    // Single requester: first write one cycle after the grant
    step();
    check("t1_lat", 32'(s_wr), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      e8 = 8'h11 * 8'(k + 1);
      check("t1_wr",   32'(s_wr),   32'd1);
      check("t1_data", 32'(s_data), 32'(e8));
    end
    step();
    check("t1_idle_busy", 32'(s_busy), 32'd0);
    check("t1_idle_data", 32'(s_data), 32'd0);
    check("t1_fifo_n", 32'(fq.size()), 32'd3);
    fq.delete();
    bus.fifo_full = 1'b0;

    // Round robin between req0 and req2, pointer starts at 1 so req2 wins first
    for (int k = 0; k < 4; k++) begin
      pq[0].push_back({1'b1, 8'hA0 + 8'(k)});
      pq[2].push_back({1'b1, 8'hC0 + 8'(k)});
    end
    gid_log.delete();
    for (int s = 0; s < 16; s++) begin
      step();
      if (s_wr) gid_log.push_back(s_gid);
    end
    check("t2_pattern", 32'(wr_hist), 32'h5555);
    check("t2_fifo_n", 32'(fq.size()), 32'd8);
    check("t2_gid_n", 32'(gid_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < fq.size() && i < gid_log.size(); i++) begin
      e8 = ((i % 2) == 0) ? (8'hC0 + 8'(i / 2)) : (8'hA0 + 8'(i / 2));
      check("t2_data", 32'(fq[i]), 32'(e8));
      check("t2_gid", 32'(gid_log[i]), ((i % 2) == 0) ? 32'd2 : 32'd0);
    end
    fq.delete();
    bus.fifo_full = 1'b0;

    // Burst cap: 6 beats with no last become 4 + 2 with a release bubble between
    for (int k = 0; k < 6; k++) pq[1].push_back({1'b0, 8'h51 + 8'(k)});
    for (int s = 0; s < 10; s++) step();
    check("t3_pattern", 32'(wr_hist[9:0]), 32'h1EC);
    check("t3_fifo_n", 32'(fq.size()), 32'd6);
    for (int i = 0; i < 6 && i < fq.size(); i++) check("t3_data", 32'(fq[i]), 32'(8'h51 + 8'(i)));
    check("t3_idle", 32'(s_busy), 32'd0);
    fq.delete();
    bus.fifo_full = 1'b0;

    // Full stall: grant held, writes only after each read, stall cycles not counted
    for (int k = 0; k < 8; k++) fq.push_back(8'hE0 + 8'(k));
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 4; k++) pq[3].push_back({1'b0, 8'h71 + 8'(k)});
    step();
    check("t4_lat", 32'(s_wr), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t4_stall_wr",   32'(s_wr),   32'd0);
      check("t4_stall_rdy",  32'(s_rdy),  32'd0);
      check("t4_stall_busy", 32'(s_busy), 32'd1);
      check("t4_stall_gid",  32'(s_gid),  32'd3);
      rd_en = 1'b1;
      step();
      check("t4_rd_wr", 32'(s_wr), 32'd0);
      step();
      check("t4_wr",   32'(s_wr),   32'd1);
      check("t4_data", 32'(s_data), 32'(8'h71 + 8'(k)));
    end
    step();
    check("t4_release", 32'(s_busy), 32'd0);
    check("t4_ovf", 32'(n_ovf), 32'd0);
    check("t4_tail", 32'(fq[fq.size()-1]), 32'h74);
    fq.delete();
    bus.fifo_full = 1'b0;

    // Reset mid-burst after 2 of 4 beats, then abandon hands over to the next requester
    for (int k = 0; k < 4; k++) pq[1].push_back({1'b0, 8'h81 + 8'(k)});
    step();
    step();
    check("t5_wr1", 32'(s_data), 32'h81);
    step();
    check("t5_wr2", 32'(s_data), 32'h82);
    drive();
    reset_n = 1'b0;
    #1;
    check("t5_rst_wr",   32'(bus.fifo_write_en), 32'd0);
    check("t5_rst_rdy",  32'(bus.req_ready),     32'd0);
    check("t5_rst_busy", 32'(bus.busy),          32'd0);
    check("t5_rst_gid",  32'(bus.grant_id),      32'd0);
    check("t5_rst_data", 32'(bus.fifo_data_in),  32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    pq[3].push_back({1'b1, 8'h93});
    step();
    check("t5_idle_gid",  32'(s_gid),  32'd0);
    check("t5_idle_busy", 32'(s_busy), 32'd0);
    step();
    check("t5_regrant_gid",  32'(s_gid),  32'd1);
    check("t5_regrant_data", 32'(s_data), 32'h83);
    step();
    check("t6_wr84", 32'(s_data), 32'h84);
    step();
    check("t6_abandon_wr",   32'(s_wr),   32'd0);
    check("t6_abandon_busy", 32'(s_busy), 32'd1);
    step();
    check("t6_idle", 32'(s_busy), 32'd0);
    step();
    check("t6_next_wr",   32'(s_wr),   32'd1);
    check("t6_next_gid",  32'(s_gid),  32'd3);
    check("t6_next_data", 32'(s_data), 32'h93);
    step();
    check("t6_done", 32'(s_busy), 32'd0);
    check("t6_fifo_n", 32'(fq.size()), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side controller that shares one `sync_fifo` write port between `NUM_REQ` producers. Each producer presents valid/data/last. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `write_en`/`data_in`. It gates every write on `full`, so no write is ever issued into a full FIFO. It sits directly in front of `sync_fifo`; the read side is untouched.

## Interface
- `NUM_REQ`, 4: number of producers, ≥2.
- `DATA_WIDTH`, 8: must match the FIFO data width.
- `MAX_BURST`, 4: maximum beats per grant, ≥1.
- `clk` in 1: single clock, all state updates on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: producer i has a beat.
- `req_data` in NUM_REQ*DATA_WIDTH: producer i data in slice [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last` in NUM_REQ: current beat of producer i ends its burst.
- `req_ready` out NUM_REQ: beat of producer i accepted this cycle (one-hot or zero).
- `fifo_full` in 1: from `sync_fifo.full`.
- `fifo_write_en` out 1: to `sync_fifo.write_en`.
- `fifo_data_in` out DATA_WIDTH: to `sync_fifo.data_in`.
- `grant_id` out $clog2(NUM_REQ): current owner; 0 when idle.
- `busy` out 1: a grant is held (state BURST).

## Operation
- State machine, 2 states:
  - IDLE → BURST at posedge if any `req_valid`. Owner = first valid index at or after `rr_ptr`, wrapping modulo NUM_REQ. `rr_ptr` ← owner+1 (mod NUM_REQ). `beat_cnt` ← 0.
  - BURST → IDLE at posedge on any of:
    - accepted beat with `req_last[owner]`;
    - accepted beat making `beat_cnt+1 == MAX_BURST`;
    - `req_valid[owner]` low (producer abandoned its burst).
  - Otherwise stay in BURST.
- Transfer condition: `xfer = busy & req_valid[owner] & ~fifo_full`. The condition is combinational.
  - `fifo_write_en = xfer`; `req_ready[owner] = xfer`; all other `req_ready` bits are 0.
- `fifo_data_in` = owner's data slice while busy, else 0.
- `beat_cnt` ($clog2(MAX_BURST+1) bits) increments only on `xfer`. Full stall cycles do not count.
- While `fifo_full`, ownership is held indefinitely with no writes; there is no timeout.
- Requests arriving in BURST from non-owners wait. No preemption.
- Reset (any time, including mid-burst) has the following effect:
  - state=IDLE, `rr_ptr`=0, `beat_cnt`=0;
  - outputs `fifo_write_en`=0, `fifo_data_in`=0, `req_ready`=0, `grant_id`=0, `busy`=0.
  - A partially written burst stays in the FIFO; clearing it is the FIFO's reset's job.

## Timing
- Arbitration latency: 1 cycle. A request first seen in IDLE at edge N gives its first write at edge N+1, when the FIFO samples `write_en`.
- One IDLE bubble cycle between consecutive grants.
- Peak throughput: MAX_BURST beats per MAX_BURST+1 cycles.
- `fifo_full` → `fifo_write_en` path is combinational, same cycle. `full` is registered in `sync_fifo`, so there is no loop.
- Producer handshake: data/last must be held stable while valid & ~ready. A beat is consumed at the posedge where `req_ready[i]`=1.
- Simultaneous last and MAX_BURST on the same beat: a single release, returning to IDLE.

## Structure
- Package `fifo_arb_pkg`: state typedef (IDLE, BURST) and default parameter constants (NUM_REQ, DATA_WIDTH, MAX_BURST).
- Sub-module `fifo_rr_pick`: purely combinational rotate-priority picker.
  - Inputs: `req_valid`, `rr_ptr`.
  - Outputs: `pick_id`, `pick_any`.
  - Reused later by the read-side scheduler.
- Top holds the FSM, `owner`, `rr_ptr`, `beat_cnt` and the output mux.

## Test plan
- Single requester: req0 sends 3 beats 0x11, 0x22, 0x33 with last on 0x33.
  - Expected: 3 consecutive `fifo_write_en` pulses one cycle after grant, FIFO holds 11, 22, 33, then IDLE.
- Round-robin: req0 and req2 both continuously valid, last on every beat.
  - Expected: grants alternate 0, 2, 0, 2; `rr_ptr` wraps; never the same owner twice while the other waits.
- Burst cap: MAX_BURST=4, req1 offers 6 beats with no last.
  - Expected: 4 writes, release, regrant, 2 more writes; data order preserved.
- Full stall: pre-fill the FIFO to 8 entries, req3 valid.
  - Expected: `busy`=1, `fifo_write_en`=0, `req_ready`=0 while full.
  - After one FIFO read, exactly one write; `beat_cnt` counts only that write.
- Reset mid-burst: drop `reset_n` after 2 of 4 beats.
  - Expected: all outputs 0 immediately (asynchronous).
  - After release, IDLE, `grant_id`=0, and arbitration restarts from index 0.
- Abandon: owner drops valid mid-burst.
  - Expected: return to IDLE next edge, and the next valid requester is granted.
